seq_decoder: RTL and testbench
==============================

Name: seq_decoder

Overview:
- Multicycle successor to the picoMIPS single-cycle instruction decoder. It sits between program memory (opcode field) and the PC, ALU, immediate mux and register file.
- Adds a parametrised opcode width, a multi-cycle MULI stall, a valid/ack handshake on the switch input for IN, JMP and HALT instructions, and a sticky illegal-opcode trap.
- The PC is held whenever the decoder stalls, so the opcode input stays stable across a stalled instruction.

Parameters:
OPW, 3, opcode width in bits; must be ≥3; opcodes compare on the full OPW bits, zero-extended encodings below.
MUL_LAT, 2, MULI execution cycles (1..15); 1 means single-cycle.

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
opcode  input  OPW  top bits of current instruction
in_valid  input  1  switch data valid
in_ack  output  1  switch data consumed this cycle
pc_incr  output  1  PC += 1 at next edge
pc_load  output  1  PC <= jump target at next edge (never with pc_incr)
alu_func  output  2  ALU function select
imm  output  2  operand mux: 00 reg, 01 switches, 11 immediate
w  output  1  register-file write enable
busy  output  1  instruction stalled this cycle
halted  output  1  in HALT state
err  output  1  sticky illegal-opcode flag
err_opcode  output  OPW  opcode that caused the trap

Behaviour:
- Encodings (fixed): NOP 0, ADD 1, ADDI 2, MULI 3, IN 4, JMP 5, HALT 6; all other values are illegal.
- alu_func = opcode[1:0] for ADD/ADDI/MULI; 00 otherwise.
- States: RUN, MUL_WAIT, IN_WAIT, HALTED, TRAP. Reset -> RUN, mul count 0, err 0, err_opcode 0.
- Outputs are combinational from state and opcode.
- In the reset cycle, all outputs are forced to 0.
- Default per cycle: pc_incr=0, pc_load=0, w=0, imm=00, in_ack=0, busy=0.
- RUN:
  - NOP: pc_incr=1.
  - ADD: w=1, imm=00, pc_incr=1.
  - ADDI: w=1, imm=11, pc_incr=1.
  - JMP: pc_load=1.
  - HALT: -> HALTED; this cycle pc_incr=0.
  - MULI with MUL_LAT=1: w=1, imm=11, pc_incr=1.
  - MULI with MUL_LAT>1: imm=11, busy=1, w=0, pc_incr=0; load count=MUL_LAT-2; -> MUL_WAIT.
  - IN with in_valid=1: w=1, imm=01, in_ack=1, pc_incr=1; stay RUN.
  - IN with in_valid=0: imm=01, busy=1; -> IN_WAIT.
  - Illegal: capture err_opcode=opcode, err=1; -> TRAP; pc_incr=0.
- MUL_WAIT:
  - imm=11, alu_func=11, busy=1.
  - If count≠0, decrement.
  - If count=0: w=1, pc_incr=1, busy=0; -> RUN.
  - The opcode input is ignored in this state.
  - Total MULI occupancy is exactly MUL_LAT cycles, with a single w pulse in the last cycle.
- IN_WAIT:
  - imm=01, busy=1 each cycle.
  - When in_valid=1: w=1, in_ack=1, pc_incr=1, busy=0; -> RUN.
  - in_valid already high on RUN entry costs no extra cycle.
  - No timeout.
- HALTED: halted=1, all strobes 0. Only reset exits.
- TRAP: err=1, all strobes 0, err_opcode is held. Only reset exits. halted=0.
- A given cycle asserts at most one of pc_incr/pc_load.
- in_ack is asserted only in the cycle w is asserted for IN.
- Reset mid-stall (MUL_WAIT, IN_WAIT) -> RUN next cycle, count cleared, no w pulse issued.
- Reset overrides in_valid and opcode.
- Back-to-back instructions: each RUN-state single-cycle op completes in 1 cycle, with no bubble after MULI or IN completion.

Test Plan:
- Reset held 2 cycles, then NOP, ADD(1), ADDI(2) -> pc_incr=1 each cycle; w=0,1,1; imm=00,00,11; alu_func=00,01,10.
- MUL_LAT=3, MULI -> busy=1,1,0; w=0,0,1; pc_incr=0,0,1; alu_func=11 all 3 cycles. MUL_LAT=1 build -> single cycle with w=1, pc_incr=1.
- IN with in_valid low 4 cycles then high -> busy=1 for 4 cycles; in_ack=w=pc_incr=1 only in cycle 5; imm=01 throughout. IN with in_valid already high -> completes in 1 cycle.
- JMP(5) -> pc_load=1, pc_incr=0, w=0. HALT(6) -> halted=1 from next cycle and stays with any opcode, until reset.
- Opcode 7 -> err=1, err_opcode=7 sticky; no pc_incr/w for 20 cycles of random opcodes; reset clears err and err_opcode to 0.
- MULI (MUL_LAT=4), assert reset in 2nd cycle -> no w pulse, RUN after reset; following ADD completes in 1 cycle.

Source files
------------

// File: rtl/seq_decoder_if.sv
// rtl/seq_decoder_if.sv - opcode/switch handshake and control strobes between decoder and datapath
interface seq_decoder_if #(
    parameter int OPW = 3
);
    logic [OPW-1:0] opcode;
    logic           in_valid;
    logic           in_ack;
    logic           pc_incr;
    logic           pc_load;
    logic [1:0]     alu_func;
    logic [1:0]     imm;
    logic           w;
    logic           busy;
    logic           halted;
    logic           err;
    logic [OPW-1:0] err_opcode;

    modport master (
        output opcode, in_valid,
        input  in_ack, pc_incr, pc_load, alu_func, imm, w, busy, halted, err, err_opcode
    );

    modport slave (
        input  opcode, in_valid,
        output in_ack, pc_incr, pc_load, alu_func, imm, w, busy, halted, err, err_opcode
    );
endinterface

// File: rtl/seq_decoder.sv
// rtl/seq_decoder.sv - multicycle picoMIPS decoder with MULI stall, IN handshake, HALT and illegal-opcode trap
module seq_decoder #(
    parameter int OPW     = 3,
    parameter int MUL_LAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    seq_decoder_if.slave bus
);
    typedef enum logic [2:0] {
        S_RUN,
        S_MUL_WAIT,
        S_IN_WAIT,
        S_HALTED,
        S_TRAP
    } state_t;

    localparam logic [OPW-1:0] OP_NOP  = OPW'(0);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(1);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(2);
    localparam logic [OPW-1:0] OP_MULI = OPW'(3);
    localparam logic [OPW-1:0] OP_IN   = OPW'(4);
    localparam logic [OPW-1:0] OP_JMP  = OPW'(5);
    localparam logic [OPW-1:0] OP_HALT = OPW'(6);

    // The RUN cycle of MULI is the first of MUL_LAT, so the wait state counts MUL_LAT-1 cycles.
    localparam logic [3:0] CNT_LOAD = (MUL_LAT > 1) ? 4'(MUL_LAT - 2) : 4'd0;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           err_q, err_d;
    logic [OPW-1:0] err_op_q, err_op_d;

    logic           in_ack, pc_incr, pc_load, w, busy, halted, err;
    logic [1:0]     alu_func, imm;
    logic [OPW-1:0] err_opcode;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_RUN;
            cnt_q    <= 4'd0;
            err_q    <= 1'b0;
            err_op_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            err_op_q <= err_op_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        err_op_d   = err_op_q;
        in_ack     = 1'b0;
        pc_incr    = 1'b0;
        pc_load    = 1'b0;
        alu_func   = 2'b00;
        imm        = 2'b00;
        w          = 1'b0;
        busy       = 1'b0;
        halted     = 1'b0;
        err        = 1'b0;
        err_opcode = '0;
        if (!reset) begin
            err        = err_q;
            err_opcode = err_op_q;
            case (state_q)
                S_RUN: begin
                    case (bus.opcode)
                        OP_NOP: pc_incr = 1'b1;
                        OP_ADD: begin
                            alu_func = bus.opcode[1:0];
                            w        = 1'b1;
                            pc_incr  = 1'b1;
                        end
                        OP_ADDI: begin
                            alu_func = bus.opcode[1:0];
                            imm      = 2'b11;
                            w        = 1'b1;
                            pc_incr  = 1'b1;
                        end
                        OP_MULI: begin
                            alu_func = bus.opcode[1:0];
                            imm      = 2'b11;
                            if (MUL_LAT == 1) begin
                                w       = 1'b1;
                                pc_incr = 1'b1;
                            end else begin
                                busy    = 1'b1;
                                cnt_d   = CNT_LOAD;
                                state_d = S_MUL_WAIT;
                            end
                        end
                        OP_IN: begin
                            imm = 2'b01;
                            if (bus.in_valid) begin
                                in_ack  = 1'b1;
                                w       = 1'b1;
                                pc_incr = 1'b1;
                            end else begin
                                busy    = 1'b1;
                                state_d = S_IN_WAIT;
                            end
                        end
                        OP_JMP:  pc_load = 1'b1;
                        OP_HALT: state_d = S_HALTED;
                        default: begin
                            err_d    = 1'b1;
                            err_op_d = bus.opcode;
                            state_d  = S_TRAP;
                        end
                    endcase
                end
                S_MUL_WAIT: begin
                    imm      = 2'b11;
                    alu_func = 2'b11;
                    if (cnt_q != 4'd0) begin
                        busy  = 1'b1;
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        w       = 1'b1;
                        pc_incr = 1'b1;
                        state_d = S_RUN;
                    end
                end
                S_IN_WAIT: begin
                    imm = 2'b01;
                    if (bus.in_valid) begin
                        in_ack  = 1'b1;
                        w       = 1'b1;
                        pc_incr = 1'b1;
                        state_d = S_RUN;
                    end else begin
                        busy = 1'b1;
                    end
                end
                S_HALTED: halted = 1'b1;
                S_TRAP:   ;
                default:  state_d = S_RUN;
            endcase
        end
    end

    assign bus.in_ack     = in_ack;
    assign bus.pc_incr    = pc_incr;
    assign bus.pc_load    = pc_load;
    assign bus.alu_func   = alu_func;
    assign bus.imm        = imm;
    assign bus.w          = w;
    assign bus.busy       = busy;
    assign bus.halted     = halted;
    assign bus.err        = err;
    assign bus.err_opcode = err_opcode;
endmodule

// File: tb/tb_seq_decoder.sv
// tb/tb_seq_decoder.sv - vector table, directed corners and randomized model check of seq_decoder
module tb_seq_decoder;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] op;
    logic       iv;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Three builds: OPW=3/MUL_LAT=3, OPW=3/MUL_LAT=1, OPW=4/MUL_LAT=4.
    seq_decoder_if #(.OPW(3)) bus3 ();
    seq_decoder_if #(.OPW(3)) bus1 ();
    seq_decoder_if #(.OPW(4)) bus4 ();

    assign bus3.opcode   = op[2:0];
    assign bus3.in_valid = iv;
    assign bus1.opcode   = op[2:0];
    assign bus1.in_valid = iv;
    assign bus4.opcode   = op;
    assign bus4.in_valid = iv;

    seq_decoder #(.OPW(3), .MUL_LAT(3)) dut3 (.clk(clk), .reset(rst), .bus(bus3));
    seq_decoder #(.OPW(3), .MUL_LAT(1)) dut1 (.clk(clk), .reset(rst), .bus(bus1));
    seq_decoder #(.OPW(4), .MUL_LAT(4)) dut4 (.clk(clk), .reset(rst), .bus(bus4));

    function automatic logic [14:0] ex(input logic ack, input logic inc, input logic ld,
                                       input logic [1:0] alu, input logic [1:0] im,
                                       input logic wr, input logic bsy, input logic hlt,
                                       input logic er, input logic [3:0] eop);
        return {ack, inc, ld, alu, im, wr, bsy, hlt, er, eop};
    endfunction

    logic [14:0] act [3];
    assign act[0] = ex(bus3.in_ack, bus3.pc_incr, bus3.pc_load, bus3.alu_func, bus3.imm,
                       bus3.w, bus3.busy, bus3.halted, bus3.err, {1'b0, bus3.err_opcode});
    assign act[1] = ex(bus1.in_ack, bus1.pc_incr, bus1.pc_load, bus1.alu_func, bus1.imm,
                       bus1.w, bus1.busy, bus1.halted, bus1.err, {1'b0, bus1.err_opcode});
    assign act[2] = ex(bus4.in_ack, bus4.pc_incr, bus4.pc_load, bus4.alu_func, bus4.imm,
                       bus4.w, bus4.busy, bus4.halted, bus4.err, bus4.err_opcode);

    // Reference model: mode plus remaining MULI occupancy cycles (including the current one).
    localparam int M_RUN = 0, M_MUL = 1, M_IN = 2, M_HALT = 3, M_TRAP = 4;
    int         m_mode [3];
    int         m_left [3];
    logic [3:0] m_eop  [3];

    function automatic int lat_of(input int i);
        return (i == 0) ? 3 : ((i == 1) ? 1 : 4);
    endfunction

    function automatic logic [3:0] op_of(input int i);
        return (i == 2) ? op : {1'b0, op[2:0]};
    endfunction

    function automatic logic [14:0] model_out(input int i);
        logic [3:0] o;
        o = op_of(i);
        if (rst) return '0;
        case (m_mode[i])
            M_RUN: begin
                case (o)
                    4'd0: return ex(0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 4'd0);
                    4'd1: return ex(0, 1, 0, 2'b01, 2'b00, 1, 0, 0, 0, 4'd0);
                    4'd2: return ex(0, 1, 0, 2'b10, 2'b11, 1, 0, 0, 0, 4'd0);
                    4'd3: return (lat_of(i) == 1) ? ex(0, 1, 0, 2'b11, 2'b11, 1, 0, 0, 0, 4'd0)
                                                  : ex(0, 0, 0, 2'b11, 2'b11, 0, 1, 0, 0, 4'd0);
                    4'd4: return iv ? ex(1, 1, 0, 2'b00, 2'b01, 1, 0, 0, 0, 4'd0)
                                    : ex(0, 0, 0, 2'b00, 2'b01, 0, 1, 0, 0, 4'd0);
                    4'd5: return ex(0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 4'd0);
                    default: return '0;
                endcase
            end
            M_MUL: return (m_left[i] == 1) ? ex(0, 1, 0, 2'b11, 2'b11, 1, 0, 0, 0, 4'd0)
                                           : ex(0, 0, 0, 2'b11, 2'b11, 0, 1, 0, 0, 4'd0);
            M_IN:  return iv ? ex(1, 1, 0, 2'b00, 2'b01, 1, 0, 0, 0, 4'd0)
                             : ex(0, 0, 0, 2'b00, 2'b01, 0, 1, 0, 0, 4'd0);
            M_HALT: return ex(0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 4'd0);
            default: return ex(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, m_eop[i]);
        endcase
    endfunction

    task automatic model_step(input int i);
        logic [3:0] o;
        o = op_of(i);
        if (rst) begin
            m_mode[i] = M_RUN;
            m_left[i] = 0;
            m_eop[i]  = 4'd0;
        end else begin
            case (m_mode[i])
                M_RUN: begin
                    if (o == 4'd3 && lat_of(i) > 1) begin
                        m_mode[i] = M_MUL;
                        m_left[i] = lat_of(i) - 1;
                    end else if (o == 4'd4 && !iv) begin
                        m_mode[i] = M_IN;
                    end else if (o == 4'd6) begin
                        m_mode[i] = M_HALT;
                    end else if (o > 4'd6) begin
                        m_mode[i] = M_TRAP;
                        m_eop[i]  = o;
                    end
                end
                M_MUL: begin
                    if (m_left[i] == 1) m_mode[i] = M_RUN;
                    else m_left[i] = m_left[i] - 1;
                end
                M_IN: if (iv) m_mode[i] = M_RUN;
                default: ;
            endcase
        end
    endtask

    task automatic check(input string name, input logic [14:0] got, input logic [14:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Drive one cycle's inputs, compare all builds to the model at negedge, advance the model.
    task automatic tick(input logic r, input logic [3:0] o, input logic v);
        @(posedge clk);
        #1;
        rst = r;
        op  = o;
        iv  = v;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("model[%0d] op%0d", i, o), act[i], model_out(i));
            model_step(i);
        end
    endtask

    typedef struct {
        logic        r;
        logic [3:0]  o;
        logic        v;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [3:0] o, input logic v, input logic [14:0] e);
        vec_t t;
        t.r = r; t.o = o; t.v = v; t.exp = e;
        tbl.push_back(t);
    endtask

    initial begin
        rst = 1'b1;
        op  = 4'd0;
        iv  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_mode[i] = M_RUN;
            m_left[i] = 0;
            m_eop[i]  = 4'd0;
        end

        // Expected values below are for the OPW=3, MUL_LAT=3 build.
        add(1, 0, 0, '0);
        add(1, 0, 0, '0);
        add(0, 0, 0, ex(0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 4'd0));
        add(0, 1, 0, ex(0, 1, 0, 2'b01, 2'b00, 1, 0, 0, 0, 4'd0));
        add(0, 2, 0, ex(0, 1, 0, 2'b10, 2'b11, 1, 0, 0, 0, 4'd0));
        add(0, 3, 0, ex(0, 0, 0, 2'b11, 2'b11, 0, 1, 0, 0, 4'd0));
        add(0, 3, 0, ex(0, 0, 0, 2'b11, 2'b11, 0, 1, 0, 0, 4'd0));
        add(0, 3, 0, ex(0, 1, 0, 2'b11, 2'b11, 1, 0, 0, 0, 4'd0));
        add(0, 1, 0, ex(0, 1, 0, 2'b01, 2'b00, 1, 0, 0, 0, 4'd0));
        for (int k = 0; k < 4; k++) add(0, 4, 0, ex(0, 0, 0, 2'b00, 2'b01, 0, 1, 0, 0, 4'd0));
        add(0, 4, 1, ex(1, 1, 0, 2'b00, 2'b01, 1, 0, 0, 0, 4'd0));
        add(0, 4, 1, ex(1, 1, 0, 2'b00, 2'b01, 1, 0, 0, 0, 4'd0));
        add(0, 5, 0, ex(0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 4'd0));
        add(0, 6, 0, '0);
        add(0, 2, 0, ex(0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 4'd0));
        add(0, 7, 1, ex(0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 4'd0));
        add(1, 0, 0, '0);
        add(0, 7, 0, '0);
        add(0, 1, 0, ex(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 4'd7));
        add(0, 0, 1, ex(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 4'd7));
        add(1, 0, 0, '0);
        add(0, 0, 0, ex(0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 4'd0));

        foreach (tbl[k]) begin
            tick(tbl[k].r, tbl[k].o, tbl[k].v);
            check($sformatf("tbl%0d", k), act[0], tbl[k].exp);
        end

        // Single-cycle MULI build.
        tick(1, 0, 0);
        tick(0, 3, 0);
        check("mul1", act[1], ex(0, 1, 0, 2'b11, 2'b11, 1, 0, 0, 0, 4'd0));

        // Reset in the second MULI cycle of the MUL_LAT=4 build: no w, then ADD in one cycle.
        tick(1, 0, 0);
        tick(0, 3, 0);
        check("mul4_c1", act[2], ex(0, 0, 0, 2'b11, 2'b11, 0, 1, 0, 0, 4'd0));
        tick(1, 3, 0);
        check("mul4_rst", act[2], '0);
        tick(0, 1, 0);
        check("mul4_add", act[2], ex(0, 1, 0, 2'b01, 2'b00, 1, 0, 0, 0, 4'd0));

        // HALT holds under arbitrary opcodes.
        tick(1, 0, 0);
        tick(0, 6, 0);
        for (int k = 0; k < 10; k++) begin
            tick(0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            check("halt_hold", act[0], ex(0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 4'd0));
        end

        // Illegal opcode trap is sticky for 20 random cycles, then reset clears it.
        tick(1, 0, 0);
        tick(0, 7, 0);
        for (int k = 0; k < 20; k++) begin
            tick(0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            check("trap_hold", act[0], ex(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 4'd7));
        end
        tick(1, 0, 0);
        check("trap_rst", act[0], '0);
        tick(0, 0, 0);
        check("trap_clear", act[0], ex(0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 4'd0));

        // Randomized traffic against the model; occasional resets escape HALT/TRAP.
        for (int k = 0; k < 600; k++) begin
            logic [3:0] o;
            o = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(0, 15));
            tick(($urandom_range(0, 24) == 0), o, ($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
